// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot check.
//   sysid_state_e : sequencer states
//   SYSID_ADDR_*  : word addresses inside the system-ID slave
//   sysid_word_t  : 32-bit data word
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_DONE
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef logic [31:0] sysid_word_t;

endpackage

// File: rtl/sysid_rd_phase.sv
// One Avalon-MM read phase: holds the read strobe and address until the
// slave accepts, waits READ_LATENCY cycles for data, and aborts the phase
// once it has run TIMEOUT_CYCLES cycles without a capture.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_go             start a new phase (overrides any phase in progress)
//   i_addr           word address for the new phase
//   i_waitrequest    slave stall
//   o_read/o_address registered Avalon read strobe and address
//   o_accept         read accepted this cycle
//   o_capture        read data is valid this cycle (capture it now)
//   o_timeout        phase aborted this cycle
module sysid_rd_phase
  import sysid_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_go,
  input  logic i_addr,
  input  logic i_waitrequest,
  output logic o_read,
  output logic o_address,
  output logic o_accept,
  output logic o_capture,
  output logic o_timeout
);

  localparam logic [1:0]  LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic        r_read;
  logic        r_addr;
  logic        r_lat_busy;
  logic [1:0]  r_lat_cnt;
  logic [15:0] r_to_cnt;

  logic w_active;
  logic w_accept;
  logic w_capture;
  logic w_timeout;

  assign w_active  = r_read | r_lat_busy;
  assign w_accept  = r_read & ~i_waitrequest;
  assign w_capture = (READ_LATENCY == 0) ? w_accept
                                         : (r_lat_busy && (r_lat_cnt == LAT_LAST));
  // The counter holds (cycles elapsed - 1); a capture in the final cycle wins.
  assign w_timeout = w_active & ~w_capture & (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read     <= 1'b0;
      r_addr     <= 1'b0;
      r_lat_busy <= 1'b0;
      r_lat_cnt  <= '0;
      r_to_cnt   <= '0;
    end else if (i_go) begin
      r_read     <= 1'b1;
      r_addr     <= i_addr;
      r_lat_busy <= 1'b0;
      r_lat_cnt  <= '0;
      r_to_cnt   <= '0;
    end else if (w_active) begin
      if (w_capture || w_timeout) begin
        r_read     <= 1'b0;
        r_lat_busy <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 16'd1;
        if (w_accept) begin
          r_read     <= 1'b0;
          r_lat_busy <= 1'b1;
          r_lat_cnt  <= '0;
        end else if (r_lat_busy) begin
          r_lat_cnt <= r_lat_cnt + 2'd1;
        end
      end
    end
  end

  assign o_read    = r_read;
  assign o_address = r_addr;
  assign o_accept  = w_accept;
  assign o_capture = w_capture;
  assign o_timeout = w_timeout;

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID check: reads the ID (word 0) and timestamp (word 1)
// from the system-ID slave, compares them with the expected build values
// and publishes pass/fail status.
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   start                request to run / re-run the sequence
//   avm_*                Avalon-MM master to the system-ID slave
//   busy                 sequence in progress
//   done                 sequence finished, held until next start
//   id_ok, ts_ok         captured words match the expected values
//   timeout              a read phase was aborted
//   id_value, ts_value   captured words
module sysid_check_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490577834,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e r_state;
  logic         r_auto;
  logic         r_busy;
  logic         r_done;
  logic         r_timeout;
  logic         r_id_ok;
  logic         r_ts_ok;
  logic         r_id_pend;
  logic         r_ts_pend;
  sysid_word_t  r_id_value;
  sysid_word_t  r_ts_value;

  logic w_go;
  logic w_go_addr;
  logic w_accept;
  logic w_capture;
  logic w_timeout;

  // Phase launch: the TS read is issued on the ID capture edge so the two
  // reads can run in consecutive cycles.
  always_comb begin
    w_go      = 1'b0;
    w_go_addr = SYSID_ADDR_ID;
    case (r_state)
      ST_IDLE:  w_go = start | r_auto;
      ST_DONE:  w_go = start;
      ST_RD_ID, ST_LAT_ID: begin
        w_go      = w_capture;
        w_go_addr = SYSID_ADDR_TS;
      end
      default: ;
    endcase
  end

  sysid_rd_phase #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_phase (
    .i_clk        (clock),
    .i_rst_n      (reset_n),
    .i_go         (w_go),
    .i_addr       (w_go_addr),
    .i_waitrequest(avm_waitrequest),
    .o_read       (avm_read),
    .o_address    (avm_address),
    .o_accept     (w_accept),
    .o_capture    (w_capture),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_auto     <= AUTO_START;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_id_pend  <= 1'b0;
      r_ts_pend  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_auto    <= 1'b0;
      r_id_pend <= 1'b0;
      r_ts_pend <= 1'b0;
      // Compare only in the cycle after a capture, so an unread word's
      // flag stays low even when its expected value is 0.
      if (r_id_pend) r_id_ok <= (r_id_value == EXPECTED_ID);
      if (r_ts_pend) r_ts_ok <= (r_ts_value == EXPECTED_TS);

      case (r_state)
        ST_IDLE: begin
          if (start || r_auto) begin
            r_state <= ST_RD_ID;
            r_busy  <= 1'b1;
          end
        end
        ST_RD_ID, ST_LAT_ID: begin
          if (w_capture) begin
            r_id_value <= avm_readdata;
            r_id_pend  <= 1'b1;
            r_state    <= ST_RD_TS;
          end else if (w_timeout) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_accept) begin
            r_state <= ST_LAT_ID;
          end
        end
        ST_RD_TS, ST_LAT_TS: begin
          if (w_capture) begin
            r_ts_value <= avm_readdata;
            r_ts_pend  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else if (w_timeout) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_accept) begin
            r_state <= ST_LAT_TS;
          end
        end
        ST_DONE: begin
          if (start) begin
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_RD_ID;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: three instances with different latency /
// timeout / auto-start settings, each with a randomized Avalon slave and a
// scoreboard fed by a sequence-level reference model.
module tb_sysid_check_ctrl;

  localparam int          NI  = 3;
  localparam logic [31:0] ETS = 32'd1490577834;

  typedef struct packed {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] id;
    logic [31:0] ts;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [NI];
  logic        start_i [NI];
  logic        wreq    [NI];
  logic [31:0] rdata   [NI];
  logic        av_addr [NI];
  logic        av_read [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        idok_v  [NI];
  logic        tsok_v  [NI];
  logic        to_v    [NI];
  logic [31:0] idv     [NI];
  logic [31:0] tsv     [NI];

  int          p_w [NI][2];
  logic [31:0] p_d [NI][2];
  exp_t        sb_q[NI][$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int to_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 16 : 12);
  endfunction

  function automatic logic [31:0] eid_of(input int i);
    return (i == 1) ? 32'hCAFE_0001 : 32'h0;
  endfunction

  // Each read phase lasts (waits + 1 + latency) cycles; if that exceeds the
  // timeout limit the phase is abandoned after exactly the limit.
  function automatic exp_t model(input int i, input int w0, input int w1,
                                 input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    int   l0;
    int   l1;
    int   t;
    e  = '0;
    t  = to_of(i);
    l0 = w0 + 1 + lat_of(i);
    l1 = w1 + 1 + lat_of(i);
    if (l0 > t) begin
      e.to  = 1'b1;
      e.cyc = 32'(t);
    end else begin
      e.id    = d0;
      e.id_ok = (d0 == eid_of(i));
      if (l1 > t) begin
        e.to  = 1'b1;
        e.cyc = 32'(l0 + t);
      end else begin
        e.ts    = d1;
        e.ts_ok = (d1 == ETS);
        e.cyc   = 32'(l0 + l1);
      end
    end
    return e;
  endfunction

  task automatic chk(input bit ok, input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s inst%0d: got %h expected %h", nm, inst, act, exp_v);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int unsigned T = (g == 0) ? 8 : ((g == 1) ? 16 : 12);

    sysid_check_ctrl #(
      .EXPECTED_ID   ((g == 1) ? 32'hCAFE_0001 : 32'h0),
      .EXPECTED_TS   (ETS),
      .READ_LATENCY  (L),
      .TIMEOUT_CYCLES(T),
      .AUTO_START    ((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clock          (clk),
      .reset_n        (rst_n[g]),
      .start          (start_i[g]),
      .avm_address    (av_addr[g]),
      .avm_read       (av_read[g]),
      .avm_waitrequest(wreq[g]),
      .avm_readdata   (rdata[g]),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .id_ok          (idok_v[g]),
      .ts_ok          (tsok_v[g]),
      .timeout        (to_v[g]),
      .id_value       (idv[g]),
      .ts_value       (tsv[g])
    );

    // Slave: stalls the planned number of cycles per word, presents the word
    // exactly in the capture cycle and garbage at every other time.
    initial begin : slave
      int          sk;
      int          swc;
      int          scd;
      logic [31:0] sdat;
      sk = 0; swc = 0; scd = 0; sdat = '0;
      wreq[g]  = 1'b0;
      rdata[g] = '0;
      forever begin
        @(negedge clk);
        rdata[g] = $urandom;
        wreq[g]  = 1'($urandom);
        if (!rst_n[g] || !busy_v[g]) begin
          sk = 0; swc = 0; scd = 0;
        end
        if (scd > 0) begin
          scd--;
          if (scd == 0) rdata[g] = sdat;
        end
        if (av_read[g]) begin
          if (sk > 1) begin
            chk(1'b0, "extra_read", g, 32'(sk), 32'd1);
          end else begin
            chk(av_addr[g] === sk[0], "address", g, 32'(av_addr[g]), 32'(sk));
            if (swc < p_w[g][sk]) begin
              wreq[g] = 1'b1;
              swc++;
            end else begin
              wreq[g] = 1'b0;
              swc = 0;
              if (L == 0) rdata[g] = p_d[g][sk];
              else begin
                scd  = int'(L);
                sdat = p_d[g][sk];
              end
              sk++;
            end
          end
        end
      end
    end

    initial begin : monitor
      int   cnt;
      bit   pb;
      bit   pd;
      bit   okp;
      exp_t e;
      cnt = 0; pb = 1'b0; pd = 1'b0; okp = 1'b0; e = '0;
      forever begin
        @(negedge clk);
        if (okp) begin
          chk(idok_v[g] === e.id_ok, "id_ok", g, 32'(idok_v[g]), 32'(e.id_ok));
          chk(tsok_v[g] === e.ts_ok, "ts_ok", g, 32'(tsok_v[g]), 32'(e.ts_ok));
          okp = 1'b0;
        end
        if (done_v[g] && !pd) begin
          chk(sb_q[g].size() != 0, "unexpected_done", g, 32'(sb_q[g].size()), 32'd1);
          if (sb_q[g].size() != 0) begin
            e = sb_q[g].pop_front();
            chk(busy_v[g] === 1'b0, "busy_at_done", g, 32'(busy_v[g]), 32'd0);
            chk(idv[g] === e.id, "id_value", g, idv[g], e.id);
            chk(tsv[g] === e.ts, "ts_value", g, tsv[g], e.ts);
            chk(to_v[g] === e.to, "timeout", g, 32'(to_v[g]), 32'(e.to));
            chk(32'(cnt) === e.cyc, "busy_cycles", g, 32'(cnt), e.cyc);
            okp = 1'b1;
          end
        end
        if (busy_v[g]) begin
          if (!pb) cnt = 0;
          cnt++;
          chk(done_v[g] === 1'b0, "done_while_busy", g, 32'(done_v[g]), 32'd0);
        end
        pb = busy_v[g];
        pd = done_v[g];
      end
    end
  end

  task automatic plan(input int i, input int w0, input int w1,
                      input logic [31:0] d0, input logic [31:0] d1);
    p_w[i][0] = w0;
    p_w[i][1] = w1;
    p_d[i][0] = d0;
    p_d[i][1] = d1;
    sb_q[i].push_back(model(i, w0, w1, d0, d1));
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (sb_q[i].size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q[i].size() != 0) begin
      chk(1'b0, "sequence_complete", i, 32'(sb_q[i].size()), 32'd0);
      sb_q[i].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Optionally pokes start again while the sequence is in flight; the last
  // possible poke lands on the final capture/timeout edge.
  task automatic run(input int i, input int w0, input int w1,
                     input logic [31:0] d0, input logic [31:0] d1, input bit poke);
    exp_t e;
    int   k;
    e = model(i, w0, w1, d0, d1);
    plan(i, w0, w1, d0, d1);
    @(negedge clk); start_i[i] = 1'b1;
    @(negedge clk); start_i[i] = 1'b0;
    if (poke) begin
      k = int'($urandom_range(e.cyc - 1, 0));
      repeat (k) @(negedge clk);
      start_i[i] = 1'b1;
      @(negedge clk); start_i[i] = 1'b0;
    end
    wait_idle(i);
  endtask

  task automatic check_zero(input int i, input string nm);
    logic [6:0] f;
    f = {busy_v[i], done_v[i], av_read[i], av_addr[i], idok_v[i], tsok_v[i], to_v[i]};
    chk(f === 7'b0, {nm, "_flags"}, i, 32'(f), 32'd0);
    chk(idv[i] === 32'h0, {nm, "_id"}, i, idv[i], 32'h0);
    chk(tsv[i] === 32'h0, {nm, "_ts"}, i, tsv[i], 32'h0);
  endtask

  function automatic int rw(input int i);
    return int'($urandom_range(32'(to_of(i) + 1), 0));
  endfunction

  function automatic logic [31:0] rid(input int i);
    return ($urandom_range(1, 0) != 0) ? eid_of(i) : $urandom;
  endfunction

  function automatic logic [31:0] rts();
    return ($urandom_range(1, 0) != 0) ? ETS : $urandom;
  endfunction

  initial begin : stim
    int n;
    for (int i = 0; i < NI; i++) begin
      rst_n[i]   = 1'b0;
      start_i[i] = 1'b0;
      p_w[i][0] = 0; p_w[i][1] = 0;
      p_d[i][0] = '0; p_d[i][1] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check_zero(i, "reset");

    // Auto-start instances run a zero-wait sequence straight out of reset.
    plan(0, 0, 0, 32'h0, ETS);
    plan(2, 0, 0, 32'h0, ETS);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    wait_idle(0);
    wait_idle(2);
    chk(busy_v[1] === 1'b0 && av_read[1] === 1'b0, "no_auto_start", 1,
        32'({busy_v[1], av_read[1]}), 32'd0);

    // Instance 0: zero latency, timeout 8.
    run(0, 5, 5, 32'h0, ETS, 1'b0);
    run(0, 0, 0, 32'h0, ETS + 32'd1, 1'b0);
    run(0, 1000, 0, 32'h0, ETS, 1'b0);
    run(0, 2, 1000, 32'h0, ETS, 1'b0);
    run(0, 7, 7, 32'h0, ETS, 1'b0);
    run(0, 8, 0, 32'h0, ETS, 1'b0);
    run(0, 0, 8, 32'h1234_5678, ETS, 1'b0);
    for (int r = 0; r < 8; r++) run(0, rw(0), rw(0), rid(0), rts(), 1'($urandom));

    // Instance 1: latency 2, manual start, extra starts poked mid-run.
    run(1, 0, 0, 32'hCAFE_0001, ETS, 1'b1);
    run(1, 3, 2, 32'hCAFE_0001, ETS, 1'b1);
    for (int r = 0; r < 8; r++) run(1, rw(1), rw(1), rid(1), rts(), 1'b1);

    // Instance 2: reset during the timestamp latency cycle.
    plan(2, 0, 3, 32'h0, ETS);
    @(negedge clk); start_i[2] = 1'b1;
    @(negedge clk); start_i[2] = 1'b0;
    n = 0;
    while (!(av_read[2] && av_addr[2] && !wreq[2]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(n < 200, "reach_ts_accept", 2, 32'(n), 32'd200);
    @(posedge clk);
    #2 rst_n[2] = 1'b0;
    #1 check_zero(2, "mid_reset");
    sb_q[2].delete();
    plan(2, 1, 0, 32'h0, ETS);
    @(negedge clk); rst_n[2] = 1'b1;
    wait_idle(2);
    for (int r = 0; r < 4; r++) run(2, rw(2), rw(2), rid(2), rts(), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
